load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block that executes the MEM_W_En / MEM_Control commands produced by the decode-stage control unit.
- Accepts one load or store request at a time and aligns store data onto byte lanes.
- Drives a single-outstanding request/grant/response data-memory bus.
- Extracts and sign/zero-extends load data before it returns to writeback.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT_RSP before a load is aborted with Bus_Err.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- Req_Valid  input  1  memory instruction present this cycle; sampled only in IDLE.
- MEM_W_En  input  1  1 = store, 0 = load.
- MEM_Control  input  3  size/extension: 000 byte, 001 halfword, 010 word, 100 byte unsigned, 101 halfword unsigned.
- Addr  input  32  byte address from the ALU.
- Store_Data  input  32  rs2 data; the low byte/halfword is used for narrow stores.
- Busy  output  1  high in REQ and WAIT_RSP; the pipeline stalls on it.
- Load_Valid  output  1  one-cycle pulse when Load_Data is valid.
- Load_Data  output  32  extended load result.
- Store_Done  output  1  one-cycle pulse when a store is granted.
- Misaligned  output  1  one-cycle pulse for a rejected misaligned request.
- Bus_Err  output  1  one-cycle pulse on load timeout.
- Bus_Req  output  1  bus request; held until Bus_Gnt.
- Bus_We  output  1  bus write enable.
- Bus_Addr  output  32  word-aligned address, {Addr[31:2], 2'b00}.
- Bus_WData  output  32  lane-replicated store data.
- Bus_Strb  output  4  byte-lane write strobes.
- Bus_Gnt  input  1  bus accepts the request this cycle.
- Bus_RValid  input  1  read data valid.
- Bus_RData  input  32  read word.

Behaviour:
- States: IDLE, REQ, WAIT_RSP.
- Reset values:
  - State goes to IDLE.
  - All pulse outputs and Bus_Req, Bus_We, Bus_Strb are 0.
  - Load_Data, Bus_Addr and Bus_WData are 32'h0.
  - The timeout counter is 0.
  - Reset mid-transaction abandons the transaction silently; no pulses are produced.

- IDLE:
  - Alignment check:
    - Halfword accesses require Addr[0] = 0.
    - Word accesses require Addr[1:0] = 00.
    - Byte accesses are always aligned.
  - Req_Valid with a misaligned address: Misaligned pulses next cycle, no bus activity, stay in IDLE.
  - Req_Valid with an aligned address:
    - Latch MEM_W_En, MEM_Control, Addr[1:0], Bus_Addr, Bus_WData and Bus_Strb.
    - Go to REQ. Bus_Req is asserted in the first REQ cycle, one cycle after acceptance.
  - Req_Valid with MEM_Control in {011, 110, 111}: treated as Misaligned (illegal size).

- Store lane formatting:
  - Byte: WData = {4{Store_Data[7:0]}}, Strb = 0001 << Addr[1:0].
  - Halfword: WData = {2{Store_Data[15:0]}}, Strb = 0011 << Addr[1:0].
  - Word: WData = Store_Data, Strb = 1111.
- Loads drive Strb = 0000 and Bus_We = 0.

- REQ:
  - Bus_Req, Bus_We, Bus_Addr, Bus_WData and Bus_Strb are held stable until Bus_Gnt.
  - On Bus_Gnt with a store: Store_Done pulses next cycle, go to IDLE.
  - On Bus_Gnt with a load: go to WAIT_RSP and clear the counter.
  - Bus_Req drops the cycle after Gnt.

- WAIT_RSP (loads only):
  - The counter increments each cycle Bus_RValid is low.
  - On Bus_RValid:
    - Select the byte at Bus_RData[8*Addr[1:0] +: 8] or the halfword at Bus_RData[16*Addr[1] +: 16].
    - Extend per MEM_Control: 000/001 sign-extend, 100/101 zero-extend, 010 pass through.
    - Register the result into Load_Data, pulse Load_Valid next cycle, go to IDLE.
  - Bus_RValid in the same cycle the counter reaches TIMEOUT_CYCLES: data wins, no error.
  - Counter reaches TIMEOUT_CYCLES without RValid: Bus_Err pulses, Load_Data = 0, go to IDLE.
  - A late RValid arriving in IDLE is ignored.

- Req_Valid while Busy is ignored; upstream must hold the instruction until Busy falls.
- Busy is 0 in the same cycle the completion pulse is high, so back-to-back requests can be accepted on that cycle.
- Load_Data holds its last value between loads.
- Bus_RValid in REQ (before Gnt) is ignored.

Test Plan:
- SB, Addr=0x1003, Store_Data=0x000000A5, Gnt after 2 cycles -> Bus_Addr=0x1000, WData=0xA5A5A5A5, Strb=1000, Bus_Req held 2 cycles, Store_Done one pulse.
- LH, Addr=0x2002, RData=0x8001_1234, immediate Gnt, RValid 3 cycles later -> Load_Data=0xFFFF8001, Load_Valid one pulse.
- LBU, Addr=0x2001, RData=0x0000F200 -> Load_Data=0x000000F2; LB of the same word -> 0xFFFFFFF2.
- LW, Addr=0x3002 -> Misaligned pulse, Bus_Req never asserted, Busy stays 0; SH at 0x3001 -> Misaligned.
- LW, Addr=0x4000, Gnt but no RValid -> Bus_Err after exactly 16 WAIT_RSP cycles, Load_Data=0, back to IDLE; late RValid ignored.
- RST asserted in WAIT_RSP, then an immediate new SW 0x5000 with 0xDEADBEEF -> no stale Load_Valid, Strb=1111, WData=0xDEADBEEF, Store_Done.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: single-outstanding request/grant/response data-memory bus
interface load_store_unit_if;
  logic        Bus_Req;
  logic        Bus_We;
  logic [31:0] Bus_Addr;
  logic [31:0] Bus_WData;
  logic [3:0]  Bus_Strb;
  logic        Bus_Gnt;
  logic        Bus_RValid;
  logic [31:0] Bus_RData;
  modport master (
    output Bus_Req, Bus_We, Bus_Addr, Bus_WData, Bus_Strb,
    input  Bus_Gnt, Bus_RValid, Bus_RData
  );
  modport slave (
    input  Bus_Req, Bus_We, Bus_Addr, Bus_WData, Bus_Strb,
    output Bus_Gnt, Bus_RValid, Bus_RData
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store sequencer with lane alignment, extension and load timeout
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req_Valid,
  input  logic        MEM_W_En,
  input  logic [2:0]  MEM_Control,
  input  logic [31:0] Addr,
  input  logic [31:0] Store_Data,
  output logic        Busy,
  output logic        Load_Valid,
  output logic [31:0] Load_Data,
  output logic        Store_Done,
  output logic        Misaligned,
  output logic        Bus_Err,
  load_store_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  ctl_q, ctl_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] ld_q, ld_d;
  logic        lv_q, lv_d, sd_q, sd_d, mis_q, mis_d, err_q, err_d;
  logic        legal, ok;
  logic [7:0]  rb;
  logic [15:0] rh;
  logic [31:0] ext, wdata_fmt;
  logic [3:0]  strb_fmt;
  // 011 and 11x are not valid sizes; the rest must be naturally aligned
  assign legal = !(MEM_Control == 3'b011 || MEM_Control[2:1] == 2'b11);
  assign ok = legal && (MEM_Control[1:0] == 2'b01 ? !Addr[0] :
                        MEM_Control[1:0] == 2'b10 ? Addr[1:0] == 2'b00 : 1'b1);
  assign wdata_fmt = MEM_Control[1:0] == 2'b00 ? {4{Store_Data[7:0]}} :
                     MEM_Control[1:0] == 2'b01 ? {2{Store_Data[15:0]}} : Store_Data;
  assign strb_fmt = !MEM_W_En ? 4'b0000 :
                    MEM_Control[1:0] == 2'b00 ? 4'b0001 << Addr[1:0] :
                    MEM_Control[1:0] == 2'b01 ? 4'b0011 << Addr[1:0] : 4'b1111;
  assign rb = bus.Bus_RData[{off_q, 3'b000} +: 8];
  assign rh = bus.Bus_RData[{off_q[1], 4'b0000} +: 16];
  assign ext = ctl_q == 3'b000 ? {{24{rb[7]}}, rb} :
               ctl_q == 3'b001 ? {{16{rh[15]}}, rh} :
               ctl_q == 3'b100 ? {24'h0, rb} :
               ctl_q == 3'b101 ? {16'h0, rh} : bus.Bus_RData;
  // next-state and completion pulses; everything defaults to hold / no pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ctl_d   = ctl_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    ld_d    = ld_q;
    lv_d    = 1'b0;
    sd_d    = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (Req_Valid) begin
        if (!ok) mis_d = 1'b1;
        else begin
          we_d    = MEM_W_En;
          ctl_d   = MEM_Control;
          off_d   = Addr[1:0];
          addr_d  = {Addr[31:2], 2'b00};
          wdata_d = wdata_fmt;
          strb_d  = strb_fmt;
          state_d = REQ;
        end
      end
      REQ: if (bus.Bus_Gnt) begin
        if (we_q) begin
          sd_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: if (bus.Bus_RValid) begin
        ld_d    = ext;
        lv_d    = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TO_LAST) begin
          ld_d    = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any transaction without pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ctl_q   <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= 4'b0000;
      ld_q    <= '0;
      lv_q    <= 1'b0;
      sd_q    <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ctl_q   <= ctl_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      ld_q    <= ld_d;
      lv_q    <= lv_d;
      sd_q    <= sd_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end
  assign Busy          = state_q != IDLE;
  assign Load_Valid    = lv_q;
  assign Load_Data     = ld_q;
  assign Store_Done    = sd_q;
  assign Misaligned    = mis_q;
  assign Bus_Err       = err_q;
  assign bus.Bus_Req   = state_q == REQ;
  assign bus.Bus_We    = state_q == REQ && we_q;
  assign bus.Bus_Addr  = addr_q;
  assign bus.Bus_WData = wdata_q;
  assign bus.Bus_Strb  = strb_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against hand-computed results
module tb_load_store_unit;
  logic        CLK, RST, Req_Valid, MEM_W_En;
  logic [2:0]  MEM_Control;
  logic [31:0] Addr, Store_Data;
  logic        Busy, Load_Valid, Store_Done, Misaligned, Bus_Err;
  logic [31:0] Load_Data;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n;
  load_store_unit_if bus ();
  load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .Req_Valid(Req_Valid), .MEM_W_En(MEM_W_En),
    .MEM_Control(MEM_Control), .Addr(Addr), .Store_Data(Store_Data),
    .Busy(Busy), .Load_Valid(Load_Valid), .Load_Data(Load_Data),
    .Store_Done(Store_Done), .Misaligned(Misaligned), .Bus_Err(Bus_Err),
    .bus(bus)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic we, input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] sd);
    Req_Valid = 1'b1; MEM_W_En = we; MEM_Control = ctl; Addr = a; Store_Data = sd;
  endtask
  task automatic do_load(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] rdata, input int waits);
    req(1'b0, ctl, a, 32'h0);
    tick;
    Req_Valid = 1'b0;
    bus.Bus_Gnt = 1'b1;
    tick;
    bus.Bus_Gnt = 1'b0;
    repeat (waits) tick;
    bus.Bus_RValid = 1'b1; bus.Bus_RData = rdata;
    tick;
    bus.Bus_RValid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    RST = 1'b1; Req_Valid = 1'b0; MEM_W_En = 1'b0; MEM_Control = 3'b000; Addr = '0; Store_Data = '0;
    bus.Bus_Gnt = 1'b0; bus.Bus_RValid = 1'b0; bus.Bus_RData = '0;
    tick; tick;
    chk("rst_busy", Busy, 0);
    chk("rst_req", bus.Bus_Req, 0);
    chk("rst_we", bus.Bus_We, 0);
    chk("rst_strb", bus.Bus_Strb, 0);
    chk("rst_addr", bus.Bus_Addr, 0);
    chk("rst_wdata", bus.Bus_WData, 0);
    chk("rst_ldata", Load_Data, 0);
    chk("rst_pulses", {Load_Valid, Store_Done, Misaligned, Bus_Err}, 0);
    RST = 1'b0;
    tick;
    req(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
    tick;
    Addr = 32'h0000_9999;
    chk("sb_req1", bus.Bus_Req, 1);
    chk("sb_busy", Busy, 1);
    chk("sb_we", bus.Bus_We, 1);
    chk("sb_addr", bus.Bus_Addr, 32'h0000_1000);
    chk("sb_wdata", bus.Bus_WData, 32'hA5A5_A5A5);
    chk("sb_strb", bus.Bus_Strb, 4'b1000);
    tick;
    Req_Valid = 1'b0;
    chk("sb_req2", bus.Bus_Req, 1);
    chk("sb_addr_held", bus.Bus_Addr, 32'h0000_1000);
    chk("sb_done_early", Store_Done, 0);
    bus.Bus_Gnt = 1'b1;
    tick;
    bus.Bus_Gnt = 1'b0;
    chk("sb_done", Store_Done, 1);
    chk("sb_req_drop", bus.Bus_Req, 0);
    chk("sb_busy_done", Busy, 0);
    tick;
    chk("sb_done_pulse", Store_Done, 0);
    req(1'b0, 3'b001, 32'h0000_2002, 32'h0);
    tick;
    Req_Valid = 1'b0;
    chk("lh_strb", bus.Bus_Strb, 4'b0000);
    chk("lh_we", bus.Bus_We, 0);
    bus.Bus_RValid = 1'b1; bus.Bus_RData = 32'hFFFF_FFFF;
    tick;
    bus.Bus_RValid = 1'b0;
    chk("lh_rvalid_in_req", {Busy, bus.Bus_Req, Load_Valid}, 3'b110);
    bus.Bus_Gnt = 1'b1;
    tick;
    bus.Bus_Gnt = 1'b0;
    chk("lh_wait", {Busy, bus.Bus_Req}, 2'b10);
    tick; tick;
    bus.Bus_RValid = 1'b1; bus.Bus_RData = 32'h8001_1234;
    tick;
    bus.Bus_RValid = 1'b0;
    chk("lh_valid", Load_Valid, 1);
    chk("lh_data", Load_Data, 32'hFFFF_8001);
    chk("lh_busy", Busy, 0);
    tick;
    chk("lh_pulse", Load_Valid, 0);
    chk("lh_hold", Load_Data, 32'hFFFF_8001);
    do_load(3'b100, 32'h0000_2001, 32'h0000_F200, 0);
    chk("lbu_data", Load_Data, 32'h0000_00F2);
    do_load(3'b000, 32'h0000_2001, 32'h0000_F200, 1);
    chk("lb_data", Load_Data, 32'hFFFF_FFF2);
    do_load(3'b101, 32'h0000_2000, 32'h1234_9876, 0);
    chk("lhu_data", Load_Data, 32'h0000_9876);
    do_load(3'b010, 32'h0000_6000, 32'h1234_5678, 15);
    chk("lw_lastcycle_valid", Load_Valid, 1);
    chk("lw_lastcycle_err", Bus_Err, 0);
    chk("lw_data", Load_Data, 32'h1234_5678);
    req(1'b0, 3'b010, 32'h0000_3002, 32'h0);
    tick;
    Req_Valid = 1'b0;
    chk("lw_mis", Misaligned, 1);
    chk("lw_mis_bus", {Busy, bus.Bus_Req}, 2'b00);
    tick;
    chk("lw_mis_pulse", {Misaligned, Busy, bus.Bus_Req}, 3'b000);
    req(1'b1, 3'b001, 32'h0000_3001, 32'h0);
    tick;
    Req_Valid = 1'b0;
    chk("sh_mis", {Misaligned, Busy}, 2'b10);
    req(1'b0, 3'b011, 32'h0000_3000, 32'h0);
    tick;
    Req_Valid = 1'b0;
    chk("illegal_mis", {Misaligned, Busy}, 2'b10);
    req(1'b0, 3'b110, 32'h0000_3000, 32'h0);
    tick;
    Req_Valid = 1'b0;
    chk("illegal110_mis", {Misaligned, Busy}, 2'b10);
    req(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    tick;
    Req_Valid = 1'b0;
    bus.Bus_Gnt = 1'b1;
    tick;
    bus.Bus_Gnt = 1'b0;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      tick;
    end
    chk("to_wait_cycles", n, 16);
    chk("to_err", Bus_Err, 1);
    chk("to_valid", Load_Valid, 0);
    chk("to_ldata", Load_Data, 0);
    bus.Bus_RValid = 1'b1; bus.Bus_RData = 32'hCAFE_F00D;
    tick;
    bus.Bus_RValid = 1'b0;
    chk("late_rvalid", {Bus_Err, Load_Valid, Busy}, 3'b000);
    chk("late_ldata", Load_Data, 0);
    req(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    tick;
    Req_Valid = 1'b0;
    bus.Bus_Gnt = 1'b1;
    tick;
    bus.Bus_Gnt = 1'b0;
    tick;
    RST = 1'b1;
    tick;
    chk("rst_mid_busy", {Busy, bus.Bus_Req, Load_Valid, Bus_Err}, 4'b0000);
    RST = 1'b0;
    req(1'b1, 3'b010, 32'h0000_5000, 32'hDEAD_BEEF);
    tick;
    Req_Valid = 1'b0;
    chk("sw_lv", Load_Valid, 0);
    chk("sw_strb", bus.Bus_Strb, 4'b1111);
    chk("sw_wdata", bus.Bus_WData, 32'hDEAD_BEEF);
    chk("sw_addr", bus.Bus_Addr, 32'h0000_5000);
    bus.Bus_Gnt = 1'b1;
    tick;
    bus.Bus_Gnt = 1'b0;
    chk("sw_done", {Store_Done, Busy, Load_Valid}, 3'b100);
    req(1'b1, 3'b001, 32'h0000_7002, 32'h1234_ABCD);
    tick;
    Req_Valid = 1'b0;
    chk("sh_b2b_req", bus.Bus_Req, 1);
    chk("sh_strb", bus.Bus_Strb, 4'b1100);
    chk("sh_wdata", bus.Bus_WData, 32'hABCD_ABCD);
    chk("sh_addr", bus.Bus_Addr, 32'h0000_7000);
    bus.Bus_Gnt = 1'b1;
    tick;
    bus.Bus_Gnt = 1'b0;
    chk("sh_done", Store_Done, 1);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
